// File: rtl/downcounter_pkg.sv
// Shared types and default constants for the loadable down-counting timer.
// Optional auto-reload is selected with the DOWNCOUNTER_AUTO_RELOAD_EN macro.
package downcounter_pkg;

  localparam int DOWNCOUNTER_WIDTH        = 8;
  localparam int DOWNCOUNTER_DEFAULT_LOAD = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } downcounter_state_e;

endpackage : downcounter_pkg

// File: rtl/downcounter_if.sv
// Start/busy handshake and count signals of the down-counting timer.
// downcounter_reload exists only when DOWNCOUNTER_AUTO_RELOAD_EN is defined.
interface downcounter_if
  import downcounter_pkg::*;
#(
  parameter int WIDTH = DOWNCOUNTER_WIDTH
);

  logic             downcounter_start;
  logic [WIDTH-1:0] downcounter_load;
  logic             downcounter_enable;
  logic             downcounter_abort;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
  logic             downcounter_reload;
`endif
  logic [WIDTH-1:0] downcounter_out;
  logic             downcounter_busy;
  logic             downcounter_done;

  modport master (
    output downcounter_start,
    output downcounter_load,
    output downcounter_enable,
    output downcounter_abort,
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
    output downcounter_reload,
`endif
    input  downcounter_out,
    input  downcounter_busy,
    input  downcounter_done
  );

  modport slave (
    input  downcounter_start,
    input  downcounter_load,
    input  downcounter_enable,
    input  downcounter_abort,
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
    input  downcounter_reload,
`endif
    output downcounter_out,
    output downcounter_busy,
    output downcounter_done
  );

endinterface : downcounter_if

// File: rtl/downcounter.sv
// Loadable down-counting timer: IDLE/RUN FSM, count register, one-cycle done pulse.
// Define DOWNCOUNTER_AUTO_RELOAD_EN to add periodic reload at expiry.
module downcounter
  import downcounter_pkg::*;
#(
  parameter int WIDTH        = DOWNCOUNTER_WIDTH,
  parameter int DEFAULT_LOAD = DOWNCOUNTER_DEFAULT_LOAD
) (
  input  logic   downcounter_clk,
  input  logic   downcounter_reset_n,
  downcounter_if.slave bus
);

  localparam logic [WIDTH-1:0] DEFAULT_VALUE = WIDTH'(DEFAULT_LOAD);

  downcounter_state_e state_reg, state_next;
  logic [WIDTH-1:0]   count_reg, count_next;
  logic               done_reg, done_next;
  logic [WIDTH-1:0]   start_value;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0]   reload_reg, reload_next;
`endif

  // A zero load selects the default period instead of an immediate expiry.
  assign start_value = (bus.downcounter_load == '0) ? DEFAULT_VALUE : bus.downcounter_load;

  always_ff @(posedge downcounter_clk or negedge downcounter_reset_n) begin
    if (!downcounter_reset_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      done_reg   <= 1'b0;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      done_reg   <= done_next;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
      reload_reg <= reload_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    done_next   = 1'b0;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
    reload_next = reload_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        // Abort is meaningless in IDLE, so a start is taken regardless of it.
        if (bus.downcounter_start) begin
          count_next  = start_value;
          state_next  = ST_RUN;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
          reload_next = start_value;
`endif
        end
      end
      ST_RUN: begin
        if (bus.downcounter_abort) begin
          state_next = ST_IDLE;
        end else if (bus.downcounter_enable) begin
          if (count_reg != '0) begin
            count_next = count_reg - WIDTH'(1);
          end else begin
            done_next = 1'b1;
`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
            if (bus.downcounter_reload) begin
              count_next = reload_reg;
            end else begin
              state_next = ST_IDLE;
            end
`else
            state_next = ST_IDLE;
`endif
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.downcounter_out  = count_reg;
  assign bus.downcounter_busy = (state_reg == ST_RUN);
  assign bus.downcounter_done = done_reg;

endmodule : downcounter

// File: tb/tb_downcounter.sv
// Self-checking bench for downcounter: directed literal checks plus random stimulus
// compared every cycle against a behavioural model of the timer.
module tb_downcounter;

  localparam int W   = 8;
  localparam int DEF = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  downcounter_if #(.WIDTH(W)) bus ();

  downcounter #(.WIDTH(W), .DEFAULT_LOAD(DEF)) dut (
    .downcounter_clk     (clk),
    .downcounter_reset_n (rst_n),
    .bus                 (bus)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  bit reload_in = 1'b0;

`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
  assign bus.downcounter_reload = reload_in;
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Behavioural model: remaining count, period, running flag, done pulse.
  int m_out = 0;
  int m_period = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  always @(negedge rst_n) begin
    m_out = 0; m_period = 0; m_busy = 1'b0; m_done = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (bus.downcounter_start) begin
          m_period = (bus.downcounter_load == 0) ? DEF : int'(bus.downcounter_load);
          m_out = m_period;
          m_busy = 1'b1;
        end
      end else if (bus.downcounter_abort) begin
        m_busy = 1'b0;
      end else if (bus.downcounter_enable) begin
        if (m_out > 0) begin
          m_out = m_out - 1;
        end else begin
          m_done = 1'b1;
          if (AUTO && reload_in) m_out = m_period;
          else m_busy = 1'b0;
        end
      end
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checks += 3;
      if (int'(bus.downcounter_out) != m_out) begin
        errors++;
        $display("FAIL model_out t=%0t got=%0d exp=%0d", $time, bus.downcounter_out, m_out);
      end
      if (bus.downcounter_busy != m_busy) begin
        errors++;
        $display("FAIL model_busy t=%0t got=%0b exp=%0b", $time, bus.downcounter_busy, m_busy);
      end
      if (bus.downcounter_done != m_done) begin
        errors++;
        $display("FAIL model_done t=%0t got=%0b exp=%0b", $time, bus.downcounter_done, m_done);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk3(input string name, input int o, input int b, input int d);
    chk({name, "_out"},  int'(bus.downcounter_out),  o);
    chk({name, "_busy"}, int'(bus.downcounter_busy), b);
    chk({name, "_done"}, int'(bus.downcounter_done), d);
    $display("txn %s: out=%0d busy=%0b done=%0b", name,
             bus.downcounter_out, bus.downcounter_busy, bus.downcounter_done);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), return at next falling edge.
  task automatic cyc(input bit s, input int l, input bit e, input bit a);
    bus.downcounter_start  = s;
    bus.downcounter_load   = W'(l);
    bus.downcounter_enable = e;
    bus.downcounter_abort  = a;
    @(negedge clk);
  endtask

  initial begin
    bus.downcounter_start  = 1'b0;
    bus.downcounter_load   = '0;
    bus.downcounter_enable = 1'b0;
    bus.downcounter_abort  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    cyc(0, 0, 1, 0);
    chk3("reset_state", 0, 0, 0);

    // Normal run, load 3
    cyc(1, 3, 1, 0); chk3("norm_load", 3, 1, 0);
    cyc(0, 0, 1, 0); chk3("norm_2", 2, 1, 0);
    cyc(0, 0, 1, 0); chk3("norm_1", 1, 1, 0);
    cyc(0, 0, 1, 0); chk3("norm_0", 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("norm_done", 0, 0, 1);
    cyc(0, 0, 1, 0); chk3("norm_idle", 0, 0, 0);

    // Zero load selects default 10; done 11 enabled cycles later
    cyc(1, 0, 1, 0); chk3("zero_load", 10, 1, 0);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 0);
    chk3("zero_at0", 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("zero_done", 0, 0, 1);

    // Stall at 2 for three cycles, start while busy ignored
    cyc(1, 4, 1, 0); chk3("stall_load", 4, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("stall_at2", 2, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 9, 0, 0);
    cyc(0, 0, 0, 0); chk3("stall_hold", 2, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("stall_at0", 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("stall_done", 0, 0, 1);

    // Abort with simultaneous start at 6
    cyc(1, 8, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("abort_at6", 6, 1, 0);
    cyc(1, 5, 1, 1); chk3("abort_taken", 6, 0, 0);
    cyc(0, 0, 1, 0); chk3("abort_idle", 6, 0, 0);
    cyc(1, 1, 1, 0); chk3("abort_restart", 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("abort_done", 0, 0, 1);
    // Back-to-back: start on the cycle right after done
    cyc(1, 2, 1, 0); chk3("b2b_load", 2, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    chk3("b2b_done", 0, 0, 1);

    // Asynchronous reset mid-run at out=5
    cyc(1, 9, 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    chk3("arst_pre", 5, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk3("arst_now", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("arst_after", 0, 0, 0);

`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
    reload_in = 1'b1;
    cyc(1, 2, 1, 0); chk3("ar_load", 2, 1, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0); chk3("ar_zero", 0, 1, 0);
      cyc(0, 0, 1, 0); chk3("ar_done", 2, 1, 1);
    end
    reload_in = 1'b0;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk3("ar_stop", 0, 0, 1);
`endif

    // Randomized stimulus; abort only while running
    for (int n = 0; n < 3000; n++) begin
      bit s, e, a;
      int l;
      s = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 9) < 8);
      a = m_busy && ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      if ($urandom_range(0, 199) == 0) l = 255;
      reload_in = ($urandom_range(0, 3) != 0);
      cyc(s, l, e, a);
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_downcounter
